// File: rtl/win_lose_judge.sv
// rtl/win_lose_judge.sv - factorization-game round referee; optional JUDGE_LOCKOUT_EN locks out a side after a wrong answer
module win_lose_judge #(
   parameter logic [23:0] TIMEOUT_CYC = 24'd5000000,
   parameter logic [7:0]  HOLD_CYC    = 8'd4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [7:0] NUMBER,
   input  logic       MY_VALID,
   input  logic [7:0] MY_F1,
   input  logic [7:0] MY_F2,
   input  logic       EN_VALID,
   input  logic [7:0] EN_F1,
   input  logic [7:0] EN_F2,
   output logic [1:0] JUDGE,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPORT} state_t;

   state_t      state;
   logic [23:0] tmo_cnt;
   logic [7:0]  hold_cnt;
   logic [7:0]  number_q;
   logic [15:0] my_prod;
   logic [15:0] en_prod;
   logic        my_fit;
   logic        en_fit;
   logic        my_ok;
   logic        en_ok;
   logic        all_locked;
   logic [1:0]  verdict;

   // full 16-bit products so an overflowing pair can never alias onto an 8-bit number
   assign my_prod = {8'd0, MY_F1} * {8'd0, MY_F2};
   assign en_prod = {8'd0, EN_F1} * {8'd0, EN_F2};
   assign my_fit  = (MY_F1 >= 8'd2) && (MY_F2 >= 8'd2) && (my_prod == {8'd0, number_q});
   assign en_fit  = (EN_F1 >= 8'd2) && (EN_F2 >= 8'd2) && (en_prod == {8'd0, number_q});

`ifdef JUDGE_LOCKOUT_EN
   logic my_lock;
   logic en_lock;
   logic my_bad;
   logic en_bad;

   assign my_ok      = MY_VALID && !my_lock && my_fit;
   assign en_ok      = EN_VALID && !en_lock && en_fit;
   assign my_bad     = MY_VALID && !my_lock && !my_fit;
   assign en_bad     = EN_VALID && !en_lock && !en_fit;
   assign all_locked = (my_lock || my_bad) && (en_lock || en_bad);

   always_ff @(posedge CLK) begin
      if (RST) begin
         my_lock <= 1'b0;
         en_lock <= 1'b0;
      end else if (state == S_IDLE && START) begin
         my_lock <= 1'b0;
         en_lock <= 1'b0;
      end else if (state == S_WAIT) begin
         if (my_bad) my_lock <= 1'b1;
         if (en_bad) en_lock <= 1'b1;
      end
   end
`else
   assign my_ok      = MY_VALID && my_fit;
   assign en_ok      = EN_VALID && en_fit;
   assign all_locked = 1'b0;
`endif

   always_comb begin
      verdict = 2'b00;
      if (my_ok && en_ok)
         verdict = 2'b11;
      else if (my_ok)
         verdict = 2'b01;
      else if (en_ok)
         verdict = 2'b10;
      else if (all_locked || (tmo_cnt == TIMEOUT_CYC - 24'd1))
         verdict = 2'b11;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         JUDGE    <= 2'b00;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         tmo_cnt  <= 24'd0;
         hold_cnt <= 8'd0;
         number_q <= 8'd0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  number_q <= NUMBER;
                  tmo_cnt  <= 24'd0;
                  BUSY     <= 1'b1;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (verdict != 2'b00) begin
                  JUDGE    <= verdict;
                  DONE     <= 1'b1;
                  hold_cnt <= 8'd0;
                  state    <= S_REPORT;
               end else begin
                  tmo_cnt <= tmo_cnt + 24'd1;
               end
            end
            S_REPORT: begin
               if (hold_cnt == HOLD_CYC - 8'd1) begin
                  JUDGE <= 2'b00;
                  BUSY  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               JUDGE <= 2'b00;
               BUSY  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_win_lose_judge.sv
// tb/tb_win_lose_judge.sv - randomized self-checking bench for win_lose_judge
module tb_win_lose_judge;

   localparam int T = 100;
   localparam int H = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [7:0] NUMBER;
   logic       MY_VALID;
   logic [7:0] MY_F1;
   logic [7:0] MY_F2;
   logic       EN_VALID;
   logic [7:0] EN_F1;
   logic [7:0] EN_F2;
   logic [1:0] JUDGE;
   logic       BUSY;
   logic       DONE;

   int total = 0;
   int bad   = 0;

   int nums [9] = '{35, 15, 77, 21, 13, 0, 255, 4, 1};
   int fa   [9] = '{5, 3, 7, 3, 1, 16, 15, 2, 1};
   int fb   [9] = '{7, 5, 11, 7, 13, 16, 17, 2, 1};

   always #5 CLK = ~CLK;

   win_lose_judge #(.TIMEOUT_CYC(24'd100), .HOLD_CYC(8'd4)) dut (
      .CLK(CLK), .RST(RST), .START(START), .NUMBER(NUMBER),
      .MY_VALID(MY_VALID), .MY_F1(MY_F1), .MY_F2(MY_F2),
      .EN_VALID(EN_VALID), .EN_F1(EN_F1), .EN_F2(EN_F2),
      .JUDGE(JUDGE), .BUSY(BUSY), .DONE(DONE)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int j, input int b, input int d);
      check({tag, ".judge"}, int'(JUDGE), j);
      check({tag, ".busy"},  int'(BUSY),  b);
      check({tag, ".done"},  int'(DONE),  d);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic bit fits(input int n, input int a, input int b);
      return (a >= 2) && (b >= 2) && (a * b == n);
   endfunction

   task automatic rand_side(input int rate, input int a, input int b,
                            output logic v, output logic [7:0] f1, output logic [7:0] f2);
      int sel;
      v   = ($urandom_range(0, 99) < rate);
      sel = $urandom_range(0, 3);
      case (sel)
         0:       begin f1 = 8'(a);  f2 = 8'(b);  end
         1:       begin f1 = 8'(b);  f2 = 8'(a);  end
         2:       begin f1 = 8'd16;  f2 = 8'd16;  end
         default: begin f1 = 8'($urandom_range(0, 20)); f2 = 8'($urandom_range(0, 20)); end
      endcase
   endtask

   task automatic run_round(input int idx, input int my_rate, input int en_rate, input bit last_only);
      int n;
      int code;
      bit my_c;
      bit en_c;
      n = nums[idx];
      for (int i = 0; i < 2; i++) begin
         rand_side(50, fa[idx], fb[idx], MY_VALID, MY_F1, MY_F2);
         rand_side(50, fa[idx], fb[idx], EN_VALID, EN_F1, EN_F2);
         START = 1'b0;
         step();
         check_out("idle", 0, 0, 0);
      end
      START = 1'b1;
      NUMBER = 8'(n);
      MY_VALID = 1'b0;
      EN_VALID = 1'b0;
      step();
      check_out("start", 0, 1, 0);
      code = 0;
      for (int k = 0; k < T && code == 0; k++) begin
         if (last_only) begin
            MY_VALID = (k == T - 1);
            MY_F1 = 8'(fa[idx]);
            MY_F2 = 8'(fb[idx]);
            EN_VALID = 1'b0;
         end else begin
            rand_side(my_rate, fa[idx], fb[idx], MY_VALID, MY_F1, MY_F2);
            rand_side(en_rate, fa[idx], fb[idx], EN_VALID, EN_F1, EN_F2);
         end
         START  = ($urandom_range(0, 7) == 0);
         NUMBER = 8'($urandom_range(0, 255));
         my_c = MY_VALID && fits(n, int'(MY_F1), int'(MY_F2));
         en_c = EN_VALID && fits(n, int'(EN_F1), int'(EN_F2));
         if (my_c && en_c)   code = 3;
         else if (my_c)      code = 1;
         else if (en_c)      code = 2;
         else if (k == T-1)  code = 3;
         step();
         if (code != 0) check_out("decide", code, 1, 1);
         else           check_out("wait", 0, 1, 0);
      end
      for (int h = 1; h < H; h++) begin
         START = $urandom_range(0, 1) == 1;
         rand_side(50, fa[idx], fb[idx], MY_VALID, MY_F1, MY_F2);
         rand_side(50, fa[idx], fb[idx], EN_VALID, EN_F1, EN_F2);
         step();
         check_out("hold", code, 1, 0);
      end
      START = 1'b1;
      step();
      check_out("release", 0, 0, 0);
      START = 1'b0;
      step();
      check_out("idle_after", 0, 0, 0);
   endtask

   initial begin
      RST = 1'b1;
      START = 1'b0;
      NUMBER = 8'd0;
      MY_VALID = 1'b0;
      MY_F1 = 8'd0;
      MY_F2 = 8'd0;
      EN_VALID = 1'b0;
      EN_F1 = 8'd0;
      EN_F2 = 8'd0;
      step();
      step();
      check_out("reset", 0, 0, 0);
      START = 1'b1;
      NUMBER = 8'd35;
      step();
      check_out("rst_start", 0, 0, 0);
      RST = 1'b0;
      START = 1'b0;
      step();
      check_out("post_reset", 0, 0, 0);

      // reset during hold
      START = 1'b1;
      NUMBER = 8'd35;
      step();
      START = 1'b0;
      check_out("r1_start", 0, 1, 0);
      MY_VALID = 1'b1;
      MY_F1 = 8'd5;
      MY_F2 = 8'd7;
      step();
      check_out("r1_win", 1, 1, 1);
      MY_VALID = 1'b0;
      step();
      check_out("r1_hold", 1, 1, 0);
      RST = 1'b1;
      step();
      check_out("r1_rst", 0, 0, 0);
      RST = 1'b0;
      step();
      check_out("r1_idle", 0, 0, 0);

      // reset during wait, then a correct answer in IDLE is ignored
      START = 1'b1;
      step();
      START = 1'b0;
      RST = 1'b1;
      step();
      check_out("r2_rst", 0, 0, 0);
      RST = 1'b0;
      MY_VALID = 1'b1;
      step();
      check_out("r2_idle_sub", 0, 0, 0);
      MY_VALID = 1'b0;

      run_round(0, 0, 0, 1'b1);
      run_round(0, 0, 0, 1'b0);
      for (int r = 0; r < 30; r++)
         run_round($urandom_range(0, 8), $urandom_range(0, 20), $urandom_range(0, 20), (r % 10) == 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
